// File: rtl/fm_sweep_sched_if.sv
// Control/config bus between the register interface and the sweep scheduler,
// plus the scheduler's outputs toward the FM modulator.
interface fm_sweep_sched_if #(
  parameter int DWELL_W = 32
);
  logic [63:0]        cfg_start_w64;
  logic [63:0]        cfg_stop_w64;
  logic [63:0]        cfg_step_w64;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [1:0]         cfg_mode;
  logic               cmd_start;
  logic               cmd_abort;
  logic [11:0]        modu_in_w12;
  logic               modu_valid;
  logic [63:0]        freq_ctrl_car;
  logic [11:0]        dac_modu_w12;
  logic               hop_stb;
  logic               busy;
  logic               done;

  modport master (
    output cfg_start_w64, cfg_stop_w64, cfg_step_w64, cfg_dwell, cfg_mode,
    output cmd_start, cmd_abort, modu_in_w12, modu_valid,
    input  freq_ctrl_car, dac_modu_w12, hop_stb, busy, done
  );

  modport slave (
    input  cfg_start_w64, cfg_stop_w64, cfg_step_w64, cfg_dwell, cfg_mode,
    input  cmd_start, cmd_abort, modu_in_w12, modu_valid,
    output freq_ctrl_car, dac_modu_w12, hop_stb, busy, done
  );
endinterface

// File: rtl/fm_sweep_sched.sv
// Carrier sweep/hop scheduler with modulation gating toward the FM modulator.
// Define FM_SWEEP_TRIANGLE_EN to build triangle (bounce) mode; otherwise mode 10 acts as sawtooth.
module fm_sweep_sched #(
  parameter int DWELL_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  fm_sweep_sched_if.slave     bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [63:0]        freq_q, freq_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               hop_q, hop_d;
  logic               done_q, done_d;
  logic [11:0]        dac_q, dac_d;

  logic [63:0]        start_q, start_d;
  logic [63:0]        end_q, end_d;
  logic [63:0]        step_q, step_d;
  logic [DWELL_W-1:0] dlen_q, dlen_d;
  logic [1:0]         mode_q, mode_d;
  logic               up_q, up_d;

  logic               busy;
  logic               is_single;
  logic               is_tri;

  // Saturating step toward endpoint e; the 65-bit sum keeps the up-sweep from wrapping.
  function automatic logic [63:0] next_point(input logic [63:0] p, input logic [63:0] e,
                                             input logic [63:0] s, input logic up);
    logic [64:0] sum;
    sum = {1'b0, p} + {1'b0, s};
    if (s == 64'd0)
      next_point = e;
    else if (up)
      next_point = (sum >= {1'b0, e}) ? e : sum[63:0];
    else
      next_point = ((p - e) <= s) ? e : (p - s);
  endfunction

  assign busy      = (state_q == S_LOAD) || (state_q == S_DWELL);
  assign is_single = (mode_q == 2'b00) || (mode_q == 2'b11);
`ifdef FM_SWEEP_TRIANGLE_EN
  assign is_tri    = (mode_q == 2'b10);
`else
  assign is_tri    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    cnt_d   = cnt_q;
    hop_d   = 1'b0;
    done_d  = 1'b0;
    start_d = start_q;
    end_d   = end_q;
    step_d  = step_q;
    dlen_d  = dlen_q;
    mode_d  = mode_q;
    up_d    = up_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.cmd_start) begin
          start_d = bus.cfg_start_w64;
          end_d   = bus.cfg_stop_w64;
          step_d  = bus.cfg_step_w64;
          dlen_d  = (bus.cfg_dwell == '0) ? '0 : bus.cfg_dwell - DWELL_W'(1);
          mode_d  = bus.cfg_mode;
          up_d    = (bus.cfg_stop_w64 >= bus.cfg_start_w64);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        freq_d  = start_q;
        cnt_d   = dlen_q;
        hop_d   = 1'b1;
        state_d = S_DWELL;
      end
      S_DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (freq_q != end_q) begin
          freq_d = next_point(freq_q, end_q, step_q, up_q);
          hop_d  = 1'b1;
          cnt_d  = dlen_q;
        end else if (is_single) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (is_tri) begin
          // Bounce: the old start becomes the new end and the sweep heads back.
          start_d = end_q;
          end_d   = start_q;
          up_d    = ~up_q;
          freq_d  = next_point(freq_q, start_q, step_q, ~up_q);
          hop_d   = 1'b1;
          cnt_d   = dlen_q;
        end else begin
          freq_d = start_q;
          hop_d  = 1'b1;
          cnt_d  = dlen_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.cmd_abort) begin
      state_d = S_IDLE;
      freq_d  = freq_q;
      cnt_d   = cnt_q;
      hop_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Modulation passes through only while a sweep is running; otherwise zero deviation.
  always_comb begin
    dac_d = 12'd2047;
    if (busy)
      dac_d = bus.modu_valid ? bus.modu_in_w12 : dac_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      freq_q  <= 64'd0;
      cnt_q   <= '0;
      hop_q   <= 1'b0;
      done_q  <= 1'b0;
      dac_q   <= 12'd2047;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      cnt_q   <= cnt_d;
      hop_q   <= hop_d;
      done_q  <= done_d;
      dac_q   <= dac_d;
    end
  end

  always_ff @(posedge clk) begin
    start_q <= start_d;
    end_q   <= end_d;
    step_q  <= step_d;
    dlen_q  <= dlen_d;
    mode_q  <= mode_d;
    up_q    <= up_d;
  end

  assign bus.freq_ctrl_car = freq_q;
  assign bus.dac_modu_w12  = dac_q;
  assign bus.hop_stb       = hop_q;
  assign bus.busy          = busy;
  assign bus.done          = done_q;

endmodule

// File: doc/fm_sweep_sched.md
# fm_sweep_sched

Sweep/hop scheduler that sequences the carrier frequency control word fed to the FM modulator and gates its modulation input. It steps a 64-bit carrier word from a start value to a stop value, by a fixed step, holding each point for a programmable dwell. It runs in single-shot, sawtooth-repeat or triangle mode. When no sweep is active it forces the 12-bit modulation sample to mid-scale (zero deviation). It sits between the control/register interface and the FM modulator input ports.

## Interface
- DWELL_W, 32, width of the dwell-count configuration
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- cfg_start_w64  in  64  first carrier word
- cfg_stop_w64  in  64  last carrier word (stop ≥ start → up-sweep, otherwise down-sweep)
- cfg_step_w64  in  64  unsigned step magnitude
- cfg_dwell  in  DWELL_W  cycles each point is held (0 treated as 1)
- cfg_mode  in  2  00 single, 01 sawtooth repeat, 10 triangle, 11 = single
- cmd_start  in  1  one-cycle start pulse
- cmd_abort  in  1  one-cycle abort pulse
- modu_in_w12  in  12  offset-binary modulation sample
- modu_valid  in  1  modu_in_w12 qualifier
- freq_ctrl_car  out  64  carrier word to FM modulator
- dac_modu_w12  out  12  modulation sample to FM modulator
- hop_stb  out  1  one-cycle pulse whenever freq_ctrl_car takes a new point
- busy  out  1  high in LOAD/DWELL
- done  out  1  one-cycle pulse on single-shot completion

## Operation
- States: IDLE, LOAD, DWELL, DONE.
- IDLE/DONE + cmd_start: latch all cfg_* into shadow registers and set direction. Go to LOAD. cfg_* changes after this point have no effect until the next start.
- LOAD: freq_ctrl_car ← start, cnt ← D−1 (D = max(cfg_dwell,1)), hop_stb=1. Go to DWELL.
- DWELL: decrement cnt each cycle. When cnt==0, evaluate the current point P:
  - P ≠ end endpoint: freq ← P±step, saturated to the end endpoint; hop_stb=1; cnt ← D−1.
  - P == end, single: go to DONE, done=1 for one cycle, freq holds stop.
  - P == end, sawtooth: freq ← start, hop_stb=1.
  - P == end, triangle: swap the endpoints and reverse direction, then step from P.
- Step arithmetic is unsigned with 65-bit intermediates; it never wraps.
  - Up-sweep: if P+step ≥ end, next = end.
  - Down-sweep: if P−end ≤ step, next = end.
- step==0 makes next = end directly (two-point sweep).
- start==stop: a single point is held for D cycles per pass.
- cmd_abort in any state: go to IDLE next cycle; freq_ctrl_car holds its last value; no done pulse. Abort wins over a simultaneous cmd_start.
- cmd_start while busy is ignored.
- dac_modu_w12: registered.
  - busy and modu_valid: ← modu_in_w12.
  - busy and !modu_valid: holds its value.
  - !busy: ← 12'd2047.

## Timing
- Reset values: freq_ctrl_car=0, dac_modu_w12=12'd2047, hop_stb=0, busy=0, done=0, state IDLE.
- Reset mid-sweep returns everything to these values immediately (asynchronous reset).
- cmd_start sampled at edge N: busy=1 after edge N; freq_ctrl_car=start and hop_stb=1 after edge N+1.
- Each point is held exactly D cycles; hop_stb coincides with the first cycle of each point.
- Single shot with K points: busy lasts 1+K·D cycles. done pulses in the cycle after the last point's final dwell cycle, while busy=0.
- dac_modu_w12 has 1-cycle latency from modu_in_w12/modu_valid. It returns to 2047 one cycle after busy falls.

## Configuration
- FM_SWEEP_TRIANGLE_EN defined: cfg_mode=10 performs triangle (bounce) sweep as above.
- Not defined: no direction-reversal logic is built, and cfg_mode=10 behaves as sawtooth (01).

## Test plan
- Single up-sweep: start=1000, stop=1300, step=100, dwell=4, mode=00.
  - freq sequence 1000,1100,1200,1300, each held 4 cycles.
  - 4 hop_stb pulses; busy lasts 17 cycles, then one done pulse; freq holds 1300.
- Saturation: start=0, stop=250, step=100, dwell=1 → sequence 0,100,200,250, then done.
- Down-sweep: start=500, stop=200, step=150, dwell=2 → sequence 500,350,200.
- Near-max saturation: start=2^64−300, stop=2^64−1, step=200 → sequence 2^64−300, 2^64−100, 2^64−1 with no wrap.
- Repeat modes: start=10, stop=30, step=10, dwell=1.
  - Sawtooth → 10,20,30,10,20,… with no done.
  - Triangle with FM_SWEEP_TRIANGLE_EN → 10,20,30,20,10,20,…
  - Triangle without the macro → sawtooth sequence.
- Abort and modulation gating:
  - modu_valid=1 with modu_in=3000: dac_modu_w12=3000 one cycle after busy rises.
  - Abort mid-dwell with simultaneous cmd_start: IDLE next cycle, freq held, no done, dac_modu_w12=2047 one cycle later.
  - A later cmd_start restarts from start.
